mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter that shares one channel of the minimal Bambu-style memory interface (oe/we/addr/Wdata/data_ram_size, Rdata/DataRdy) between two requesters, e.g. the HLS `main` core and a host preload/readback engine. Round-robin grant per access, a hold-until-DataRdy lock, and a watchdog that aborts accesses the slave never acknowledges. It sits between the masters and the off-chip memory model or controller, one instance per channel.

## Interface
- ADDR_W, 11, address width per channel
- DATA_W, 8, data width per channel
- SIZE_W, 4, data_ram_size field width per channel
- TIMEOUT, 64, max cycles in BUSY without DataRdy before abort (≥2)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- m0_oe, m0_we  in  1 each  master 0 read / write request, held until m0_datardy
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_size  in  SIZE_W  master 0 access size in bits
- m0_rdata  out  DATA_W  read data to master 0
- m0_datardy  out  1  access complete, 1-cycle pulse
- m0_err  out  1  watchdog abort, 1-cycle pulse coincident with m0_datardy
- m1_*  same set for master 1
- s_oe, s_we  out  1 each  slave request
- s_addr  out  ADDR_W;  s_wdata  out  DATA_W;  s_size  out  SIZE_W
- s_rdata  in  DATA_W  slave read data
- s_datardy  in  1  slave completion
- grant  out  2  one-hot current owner (bit0 = m0), 0 when idle
- busy  out  1  high in BUSY

## Operation
- Request from master i: req_i = mi_oe | mi_we. Master must hold all request signals stable until it sees mi_datardy.
- FSM states IDLE, BUSY.
- IDLE: if any req_i, register grant (both requesting: grant master ≠ last_owner; one requesting: that master); last_owner <= granted; go BUSY. Else stay.
- BUSY: slave outputs = granted master's oe/we/addr/wdata/size (combinational mux from registered grant). Timeout counter increments each BUSY cycle.
  - s_datardy=1: mi_datardy=1 for granted master (combinational), mi_rdata = s_rdata; next state IDLE, grant cleared, counter cleared.
  - counter reaches TIMEOUT-1 with no s_datardy: mi_datardy=1, mi_err=1, mi_rdata=0 for granted master; next state IDLE. s_oe/s_we still driven that cycle.
  - Granted master drops request while BUSY (protocol violation): slave signals follow it to 0; arbiter stays BUSY until s_datardy or timeout.
- Outside BUSY, and for non-granted master: s_oe=s_we=0, s_addr/s_wdata/s_size=0, mi_rdata=0, mi_datardy=0, mi_err=0. Zero rdata is mandatory: upstream ORs rdata buses.
- oe and we both set by one master: forwarded unchanged; slave flags the error.
- Counter width clog2(TIMEOUT); no wrap possible since it clears on exit.

## Timing
- Reset (async assert): state IDLE, grant=0, busy=0, counter=0, last_owner=m1 (so m0 wins first tie); all outputs 0. Deassertion takes effect at next rising edge.
- Request first visible in cycle N (IDLE) → grant/busy/s_oe high in N+1.
- Slave read delay 2 (DataRdy in 2nd cycle of request): s_datardy and mi_datardy in N+2, IDLE in N+3; next grant visible N+4. Read throughput 1 per 3 cycles per channel.
- Slave write delay 1: datardy in N+1, IDLE in N+2.
- Master sampling mi_datardy at edge ending cycle k drops request in k+1; arbiter is IDLE in k+1 so the dropped request is never re-granted.
- Reset mid-BUSY: slave request drops immediately (async); no datardy/err issued; in-flight access is lost.

## Test plan
- Single read: m0_oe, addr=0x100, size=8 at N, slave delay 2 returns 0xA5 → s_oe high N+1..N+2, m0_datardy and m0_rdata=0xA5 in N+2, m1_rdata=0 throughout, grant=0 at N+3.
- Tie and fairness: both masters request reads continuously from reset → grants alternate m0,m1,m0,m1; each access 3 cycles; no master waits more than one access.
- Write: m1_we, addr=0x7FF, wdata=0x3C, size=8, slave delay 1 → s_we/s_addr=0x7FF/s_wdata=0x3C in N+1, m1_datardy N+1, busy low N+2.
- Timeout: TIMEOUT=8, slave never acks m0 read → m0_datardy and m0_err pulse in 8th BUSY cycle, m0_rdata=0, then pending m1 request granted next IDLE cycle.
- Reset mid-access: assert reset in 2nd BUSY cycle → s_oe, grant, busy 0 in same cycle (async); after release m0 wins a tie first.
- Rdata isolation: slave drives s_rdata=0xFF continuously while m1 granted → m0_rdata stays 0 in every cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// One channel of a minimal Bambu-style memory interface: the request side
// (oe/we/addr/wdata/size) and the response side (rdata/datardy/err).
//
// Modports
//   master : drives oe, we, addr, wdata, size; receives rdata, datardy, err
//   slave  : receives oe, we, addr, wdata, size; drives rdata, datardy, err
//
// The arbiter connects to each requester through the slave modport. It
// connects to the memory through the master modport. The memory side never
// drives err, so whoever sits there ties it low.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic              oe;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] rdata;
    logic              datardy;
    logic              err;

    modport master (
        output oe, we, addr, wdata, size,
        input  rdata, datardy, err
    );

    modport slave (
        input  oe, we, addr, wdata, size,
        output rdata, datardy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory channel between two requesters. Each access is granted
// round-robin and then held until the slave signals DataRdy. A watchdog
// aborts an access that the slave never acknowledges.
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   m0, m1 : requester channels (slave modport). Each requester holds its
//            request until it sees datardy.
//   s      : channel to the memory (master modport)
//   grant  : one-hot current owner (bit0 = m0); zero while idle
//   busy   : high while an access is in flight
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   m0,
    mem_port_arbiter_if.slave   m1,
    mem_port_arbiter_if.master  s,
    output logic [1:0]          grant,
    output logic                busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_grant;
    logic [1:0]        w_nextGrant;
    logic              r_lastOwner;
    logic              w_nextLastOwner;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_nextCount;

    logic              w_req0;
    logic              w_req1;
    logic              w_pickM1;
    logic              w_sel0;
    logic              w_sel1;
    logic              w_timeout;

    logic              w_sOe;
    logic              w_sWe;
    logic [ADDR_W-1:0] w_sAddr;
    logic [DATA_W-1:0] w_sWdata;
    logic [SIZE_W-1:0] w_sSize;

    assign w_req0 = m0.oe | m0.we;
    assign w_req1 = m1.oe | m1.we;

    // On a tie, the master that did not own the previous access wins.
    // r_lastOwner = 1 means m1 owned it last.
    assign w_pickM1 = (w_req0 && w_req1) ? ~r_lastOwner : w_req1;

    // The grant register is cleared whenever the arbiter leaves BUSY.
    // Qualifying with the state therefore only guards against a corrupted
    // grant value.
    assign w_sel0 = (r_state == BUSY) && r_grant[0];
    assign w_sel1 = (r_state == BUSY) && r_grant[1];

    // An acknowledgement in the final watchdog cycle still counts as a
    // normal completion.
    assign w_timeout = (r_state == BUSY) && !s.datardy && (r_count == CNT_LAST);

    // State register. Reset leaves m1 as the last owner, so m0 wins the
    // first tie after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_lastOwner <= 1'b1;
            r_count     <= '0;
        end else begin
            r_state     <= w_nextState;
            r_grant     <= w_nextGrant;
            r_lastOwner <= w_nextLastOwner;
            r_count     <= w_nextCount;
        end
    end

    // Next-state logic. Requests are arbitrated only in IDLE. A BUSY access
    // ends on an acknowledgement or on the watchdog, whichever comes first.
    always_comb begin
        w_nextState     = r_state;
        w_nextGrant     = r_grant;
        w_nextLastOwner = r_lastOwner;
        w_nextCount     = r_count;
        case (r_state)
            IDLE: begin
                w_nextCount = '0;
                if (w_req0 || w_req1) begin
                    w_nextGrant     = w_pickM1 ? 2'b10 : 2'b01;
                    w_nextLastOwner = w_pickM1;
                    w_nextState     = BUSY;
                end
            end
            BUSY: begin
                if (s.datardy || w_timeout) begin
                    w_nextState = IDLE;
                    w_nextGrant = 2'b00;
                    w_nextCount = '0;
                end else begin
                    w_nextCount = r_count + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGrant = 2'b00;
                w_nextCount = '0;
            end
        endcase
    end

    // Output steering. The owner's request passes straight through to the
    // slave, so a master that drops its request mid-access drops the slave
    // request too. Every bus that is not selected is held at zero, because
    // the rdata buses are ORed together upstream.
    always_comb begin
        w_sOe      = 1'b0;
        w_sWe      = 1'b0;
        w_sAddr    = '0;
        w_sWdata   = '0;
        w_sSize    = '0;
        m0.rdata   = '0;
        m0.datardy = 1'b0;
        m0.err     = 1'b0;
        m1.rdata   = '0;
        m1.datardy = 1'b0;
        m1.err     = 1'b0;
        if (w_sel0) begin
            w_sOe      = m0.oe;
            w_sWe      = m0.we;
            w_sAddr    = m0.addr;
            w_sWdata   = m0.wdata;
            w_sSize    = m0.size;
            m0.datardy = s.datardy | w_timeout;
            m0.err     = w_timeout;
            if (s.datardy) begin
                m0.rdata = s.rdata;
            end
        end else if (w_sel1) begin
            w_sOe      = m1.oe;
            w_sWe      = m1.we;
            w_sAddr    = m1.addr;
            w_sWdata   = m1.wdata;
            w_sSize    = m1.size;
            m1.datardy = s.datardy | w_timeout;
            m1.err     = w_timeout;
            if (s.datardy) begin
                m1.rdata = s.rdata;
            end
        end
    end

    assign s.oe    = w_sOe;
    assign s.we    = w_sWe;
    assign s.addr  = w_sAddr;
    assign s.wdata = w_sWdata;
    assign s.size  = w_sSize;

    assign grant = r_grant;
    assign busy  = (r_state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT = 8. Inputs change 1 ns
// after each rising edge, and outputs are sampled 4 ns after that edge.
// Each scenario task steps the clock itself and checks its expected values
// inline.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] grant;
    logic       busy;

    int nCompared   = 0;
    int nMismatched = 0;

    mem_port_arbiter_if m0_if ();
    mem_port_arbiter_if m1_if ();
    mem_port_arbiter_if s_if ();

    mem_port_arbiter #(
        .ADDR_W  (11),
        .DATA_W  (8),
        .SIZE_W  (4),
        .TIMEOUT (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if.slave),
        .m1    (m1_if.slave),
        .s     (s_if.master),
        .grant (grant),
        .busy  (busy)
    );

    // 10 ns clock period.
    always #5 clock = ~clock;

    // Absolute time limit, so the bench always ends.
    initial begin
        #50000;
        $display("[TB] FAIL time_limit: got timeout, want finish");
        $fatal(1, "[TB] time limit expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        m0_if.oe = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.size = '0;
        m1_if.oe = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.size = '0;
        s_if.rdata = '0; s_if.datardy = 0; s_if.err = 0;
        reset = 1'b0;
        #3;
        nCompared++; if (grant !== 2'b00) begin nMismatched++; $display("[TB] FAIL rst_grant: got %b want 00", grant); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        nCompared++; if (s_if.oe !== 1'b0 || s_if.we !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_s_req: got oe=%b we=%b want 0/0", s_if.oe, s_if.we); end
        nCompared++; if (m0_if.datardy !== 1'b0 || m1_if.datardy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_datardy: got %b%b want 00", m1_if.datardy, m0_if.datardy); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        // Cycle N: the request appears while the arbiter is IDLE.
        nextCycle();
        m0_if.oe = 1; m0_if.addr = 11'h100; m0_if.size = 4'd8;
        #3;
        nCompared++; if (s_if.oe !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_idle: got s_oe=%b busy=%b want 0/0", s_if.oe, busy); end
        // Cycle N+1: the grant is registered and the request is forwarded.
        nextCycle();
        #3;
        nCompared++; if (grant !== 2'b01) begin nMismatched++; $display("[TB] FAIL rd_grant: got %b want 01", grant); end
        nCompared++; if (s_if.oe !== 1'b1 || s_if.addr !== 11'h100 || s_if.size !== 4'd8) begin nMismatched++; $display("[TB] FAIL rd_fwd: got oe=%b addr=%h size=%0d want 1/100/8", s_if.oe, s_if.addr, s_if.size); end
        nCompared++; if (m0_if.datardy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_early_rdy: got %b want 0", m0_if.datardy); end
        // Cycle N+2: the slave acknowledges with 0xA5.
        nextCycle();
        s_if.datardy = 1; s_if.rdata = 8'hA5;
        #3;
        nCompared++; if (m0_if.datardy !== 1'b1 || m0_if.rdata !== 8'hA5) begin nMismatched++; $display("[TB] FAIL rd_data: got rdy=%b rdata=%h want 1/a5", m0_if.datardy, m0_if.rdata); end
        nCompared++; if (m1_if.rdata !== 8'h00 || m1_if.datardy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_m1_iso: got rdata=%h rdy=%b want 00/0", m1_if.rdata, m1_if.datardy); end
        nCompared++; if (s_if.oe !== 1'b1 || m0_if.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_oe_hold: got oe=%b err=%b want 1/0", s_if.oe, m0_if.err); end
        // Cycle N+3: the master drops its request and the arbiter is IDLE.
        nextCycle();
        m0_if.oe = 0; m0_if.addr = '0; m0_if.size = '0;
        s_if.datardy = 0; s_if.rdata = '0;
        #3;
        nCompared++; if (grant !== 2'b00 || busy !== 1'b0 || s_if.oe !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_release: got grant=%b busy=%b oe=%b want 00/0/0", grant, busy, s_if.oe); end
    endtask

    task automatic test_write();
        nextCycle();
        m1_if.we = 1; m1_if.addr = 11'h7FF; m1_if.wdata = 8'h3C; m1_if.size = 4'd8;
        // The slave acknowledges in the first BUSY cycle.
        nextCycle();
        s_if.datardy = 1;
        #3;
        nCompared++; if (s_if.we !== 1'b1 || s_if.oe !== 1'b0 || s_if.addr !== 11'h7FF || s_if.wdata !== 8'h3C) begin nMismatched++; $display("[TB] FAIL wr_fwd: got we=%b oe=%b addr=%h wdata=%h want 1/0/7ff/3c", s_if.we, s_if.oe, s_if.addr, s_if.wdata); end
        nCompared++; if (grant !== 2'b10) begin nMismatched++; $display("[TB] FAIL wr_grant: got %b want 10", grant); end
        nCompared++; if (m1_if.datardy !== 1'b1 || m1_if.err !== 1'b0 || m0_if.datardy !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr_rdy: got m1rdy=%b m1err=%b m0rdy=%b want 1/0/0", m1_if.datardy, m1_if.err, m0_if.datardy); end
        nextCycle();
        m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.size = '0;
        s_if.datardy = 0;
        #3;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr_busy_low: got %b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [1:0] expGrant;
        logic [7:0] expData;
        // m1 owned the last access, so m0 is granted first.
        for (int k = 0; k < 4; k++) begin
            expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
            expData  = 8'h10 + 8'(k);
            nextCycle();
            s_if.datardy = 0; s_if.rdata = '0;
            if (k == 0) begin
                m0_if.oe = 1; m0_if.addr = 11'h010;
                m1_if.oe = 1; m1_if.addr = 11'h020;
            end
            #3;
            nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rr_idle_%0d: got busy=%b want 0", k, busy); end
            nextCycle();
            #3;
            nCompared++; if (grant !== expGrant) begin nMismatched++; $display("[TB] FAIL rr_grant_%0d: got %b want %b", k, grant, expGrant); end
            nextCycle();
            s_if.datardy = 1; s_if.rdata = expData;
            #3;
            if (expGrant == 2'b01) begin
                nCompared++; if (m0_if.datardy !== 1'b1 || m0_if.rdata !== expData || m1_if.datardy !== 1'b0 || m1_if.rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL rr_resp_%0d: got m0=%b/%h m1=%b/%h want 1/%h 0/00", k, m0_if.datardy, m0_if.rdata, m1_if.datardy, m1_if.rdata, expData); end
            end else begin
                nCompared++; if (m1_if.datardy !== 1'b1 || m1_if.rdata !== expData || m0_if.datardy !== 1'b0 || m0_if.rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL rr_resp_%0d: got m1=%b/%h m0=%b/%h want 1/%h 0/00", k, m1_if.datardy, m1_if.rdata, m0_if.datardy, m0_if.rdata, expData); end
            end
        end
        nextCycle();
        m0_if.oe = 0; m0_if.addr = '0; m1_if.oe = 0; m1_if.addr = '0;
        s_if.datardy = 0; s_if.rdata = '0;
        #3;
        nCompared++; if (busy !== 1'b0 || grant !== 2'b00) begin nMismatched++; $display("[TB] FAIL rr_end: got busy=%b grant=%b want 0/00", busy, grant); end
    endtask

    task automatic test_timeout();
        // Both masters request. m1 owned the last access, so m0 is granted,
        // and the slave never acknowledges it.
        nextCycle();
        m0_if.oe = 1; m0_if.addr = 11'h055;
        m1_if.oe = 1; m1_if.addr = 11'h066;
        s_if.rdata = 8'h77;
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            #3;
            if (i < 8) begin
                nCompared++; if (m0_if.datardy !== 1'b0 || m0_if.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_early_%0d: got rdy=%b err=%b want 0/0", i, m0_if.datardy, m0_if.err); end
            end else begin
                nCompared++; if (m0_if.datardy !== 1'b1 || m0_if.err !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_abort: got rdy=%b err=%b want 1/1", m0_if.datardy, m0_if.err); end
                nCompared++; if (m0_if.rdata !== 8'h00 || s_if.oe !== 1'b1) begin nMismatched++; $display("[TB] FAIL to_abort_bus: got rdata=%h oe=%b want 00/1", m0_if.rdata, s_if.oe); end
                nCompared++; if (m1_if.datardy !== 1'b0 || m1_if.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_m1_quiet: got rdy=%b err=%b want 0/0", m1_if.datardy, m1_if.err); end
            end
        end
        nextCycle();
        m0_if.oe = 0; m0_if.addr = '0;
        #3;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_idle: got busy=%b want 0", busy); end
        nextCycle();
        #3;
        nCompared++; if (grant !== 2'b10 || s_if.addr !== 11'h066) begin nMismatched++; $display("[TB] FAIL to_next_grant: got grant=%b addr=%h want 10/066", grant, s_if.addr); end
        nextCycle();
        s_if.datardy = 1; s_if.rdata = 8'h42;
        #3;
        nCompared++; if (m1_if.datardy !== 1'b1 || m1_if.rdata !== 8'h42 || m1_if.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_m1_done: got rdy=%b rdata=%h err=%b want 1/42/0", m1_if.datardy, m1_if.rdata, m1_if.err); end
        nextCycle();
        m1_if.oe = 0; m1_if.addr = '0;
        s_if.datardy = 0; s_if.rdata = '0;
    endtask

    task automatic test_reset_mid();
        // m0 alone is granted, which leaves m0 as the last owner.
        nextCycle();
        m0_if.oe = 1; m0_if.addr = 11'h123;
        nextCycle();
        nextCycle();
        // Second BUSY cycle: assert reset partway through.
        #2;
        reset = 1'b0;
        #1;
        nCompared++; if (s_if.oe !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_async: got oe=%b grant=%b busy=%b want 0/00/0", s_if.oe, grant, busy); end
        nCompared++; if (m0_if.datardy !== 1'b0 || m0_if.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_no_rdy: got rdy=%b err=%b want 0/0", m0_if.datardy, m0_if.err); end
        m1_if.oe = 1; m1_if.addr = 11'h321;
        @(negedge clock);
        reset = 1'b1;
        // With both requesting, m0 must win because reset restored m1 as
        // the last owner.
        nextCycle();
        #3;
        nCompared++; if (grant !== 2'b01 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rm_tie: got grant=%b busy=%b want 01/1", grant, busy); end
        nextCycle();
        s_if.datardy = 1; s_if.rdata = 8'h5A;
        #3;
        nCompared++; if (m0_if.datardy !== 1'b1 || m0_if.rdata !== 8'h5A) begin nMismatched++; $display("[TB] FAIL rm_done: got rdy=%b rdata=%h want 1/5a", m0_if.datardy, m0_if.rdata); end
        nextCycle();
        m0_if.oe = 0; m0_if.addr = '0; m1_if.oe = 0; m1_if.addr = '0;
        s_if.datardy = 0; s_if.rdata = '0;
        #3;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_rdata_isolation();
        // The slave drives 0xFF throughout. m0 owned the last access, so m1
        // wins the tie.
        s_if.rdata = 8'hFF;
        nextCycle();
        m0_if.oe = 1; m0_if.addr = 11'h00A;
        m1_if.oe = 1; m1_if.addr = 11'h00B;
        #3;
        nCompared++; if (m0_if.rdata !== 8'h00 || m1_if.rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL iso_idle: got m0=%h m1=%h want 00/00", m0_if.rdata, m1_if.rdata); end
        nextCycle();
        #3;
        nCompared++; if (grant !== 2'b10 || m0_if.rdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL iso_b1: got grant=%b m0rdata=%h want 10/00", grant, m0_if.rdata); end
        nextCycle();
        s_if.datardy = 1;
        #3;
        nCompared++; if (m1_if.datardy !== 1'b1 || m1_if.rdata !== 8'hFF) begin nMismatched++; $display("[TB] FAIL iso_m1: got rdy=%b rdata=%h want 1/ff", m1_if.datardy, m1_if.rdata); end
        nCompared++; if (m0_if.rdata !== 8'h00 || m0_if.datardy !== 1'b0) begin nMismatched++; $display("[TB] FAIL iso_m0: got rdata=%h rdy=%b want 00/0", m0_if.rdata, m0_if.datardy); end
        nextCycle();
        m0_if.oe = 0; m0_if.addr = '0; m1_if.oe = 0; m1_if.addr = '0;
        s_if.datardy = 0;
        #3;
        nCompared++; if (m0_if.rdata !== 8'h00 || m1_if.rdata !== 8'h00 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL iso_after: got m0=%h m1=%h busy=%b want 00/00/0", m0_if.rdata, m1_if.rdata, busy); end
        s_if.rdata = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_rdata_isolation();
        nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
